oob_host_seq: RTL
=================

# oob_host_seq

Host-side SATA out-of-band sequencer. It drives the burst-enable and primitive-select inputs of the serial burst transmitter through COMRESET, COMWAKE, ALIGN and SYNC. It consumes the squelch/OOB detector flags and retries on timeout. It reports link-up to the link layer and sits between the PHY transmitter/OOB detector and the link-layer bring-up logic.

## Interface
- UIOOB, 160: burst length in i_clk cycles; the COMWAKE gap is also UIOOB.
- RESET_GAP, 480: COMRESET gap length in cycles (3×UIOOB).
- N_BURST, 6: bursts per COMRESET/COMWAKE sequence.
- T_WAIT, 4096: cycles to wait for a device response (COMINIT, COMWAKE or ALIGN).
- MAX_RETRY, 3: COMRESET attempts before failure.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_start  in  1  begin bring-up (pulse).
- i_cominit_det  in  1  detector saw COMINIT.
- i_comwake_det  in  1  detector saw COMWAKE.
- i_align_det  in  1  receiver locked on ALIGNp.
- o_burst_en  out  1  transmitter burst enable.
- o_prim_sel  out  2  primitive to transmit: 0=ALIGN, 1=SYNC, 2/3 reserved.
- o_link_up  out  1  sequence complete; SYNC being sent.
- o_fail  out  1  retries exhausted.
- o_state  out  3  current FSM state, for debug.
- o_retry_cnt  out  2  COMRESET attempts made in the current bring-up.

## Operation
- States: IDLE=0, COMRESET=1, WAIT_CI=2, COMWAKE=3, WAIT_CW=4, ALIGN=5, LINK_UP=6, FAIL=7.
- IDLE: outputs low. i_start → COMRESET; retry_cnt ← 1.
- COMRESET and COMWAKE: N_BURST repetitions of a burst then a gap.
  - Burst: o_burst_en=1 for UIOOB cycles.
  - Gap: o_burst_en=0 for the gap length, RESET_GAP in COMRESET and UIOOB in COMWAKE.
  - The final gap is included. The state then advances to WAIT_CI or WAIT_CW respectively.
  - Detector inputs are ignored during these states.
- WAIT_CI:
  - i_cominit_det → COMWAKE.
  - Wait counter reaching T_WAIT-1 with retry_cnt<MAX_RETRY → COMRESET, retry_cnt+1.
  - Wait counter reaching T_WAIT-1 with retry_cnt=MAX_RETRY → FAIL.
  - Detect and timeout in the same cycle: detect wins.
- WAIT_CW:
  - i_comwake_det → ALIGN.
  - Timeout → COMRESET, with the same retry/fail rules as WAIT_CI.
- ALIGN:
  - o_burst_en=1 continuously, o_prim_sel=0.
  - i_align_det → LINK_UP.
  - Timeout → COMRESET under the retry rules.
- LINK_UP:
  - o_burst_en=1, o_prim_sel=1, o_link_up=1.
  - i_cominit_det (device-initiated reset) → COMWAKE, o_link_up drops.
- FAIL: o_fail=1, o_burst_en=0. i_start → COMRESET with retry_cnt←1.
- i_start is ignored in every state except IDLE and FAIL.
- Counters:
  - Phase counter: width $clog2(max(UIOOB,RESET_GAP)).
  - Burst counter: width $clog2(N_BURST+1).
  - Wait counter: width $clog2(T_WAIT).
  - All three clear on every state change.

## Timing
- Reset (asynchronous assert): state=IDLE, all outputs 0, o_prim_sel=0, all counters 0. Deassertion is synchronized externally.
- All outputs are registered.
- i_start sampled high in cycle n → o_burst_en=1 from cycle n+1.
- Exact COMRESET duration: N_BURST×(UIOOB+RESET_GAP) cycles. With defaults this is 3840 cycles; o_state=WAIT_CI at cycle n+1+3840.
- Detector pulse sampled in cycle m → state change visible at m+1. o_burst_en/o_prim_sel follow in the same cycle.
- Reset mid-sequence aborts immediately, with no trailing gap.

## Structure
- Shared package oob_pkg holds:
  - the state encoding;
  - the o_prim_sel codes (PRIM_ALIGN=0, PRIM_SYNC=1);
  - the default timing constants UIOOB, RESET_GAP, N_BURST.
- One sub-module, oob_burst_timer: generates burst/gap sequences given burst length, gap length and count. It has a start pulse input and a done pulse output, and is reused for COMRESET and COMWAKE.
- The FSM, wait counter and retry logic live in oob_host_seq.

## Test plan
Parameters for all scenarios: UIOOB=4, RESET_GAP=12, N_BURST=2, T_WAIT=20, MAX_RETRY=3.
- Reset check: reset, then i_start at cycle 10 → o_burst_en high cycles 11-14 and 27-30, low elsewhere; o_state=2 at cycle 43.
- Nominal bring-up: COMINIT 3 cycles into WAIT_CI → COMWAKE with bursts at 4-cycle burst / 4-cycle gap pitch (16 cycles); then COMWAKE det → ALIGN with o_prim_sel=0; then align det → o_link_up=1 and o_prim_sel=1 next cycle.
- Retry path: no COMINIT ever → three COMRESET sequences with o_retry_cnt 1,2,3; o_fail=1 at 20 cycles after the third WAIT_CI entry.
- Race and ignore rules:
  - COMINIT and timeout in the same cycle → COMWAKE, o_retry_cnt unchanged.
  - i_start during COMWAKE → ignored.
- Device reset: i_cominit_det while LINK_UP → o_link_up=0 next cycle, o_state=3.
- Reset mid-burst: i_rst_n low during the second COMRESET burst → o_burst_en=0 asynchronously, o_state=0, o_retry_cnt=0.

Source files
------------

// File: rtl/oob_pkg.sv
// Shared definitions for the host-side SATA OOB sequencer: state encoding,
// primitive-select codes and default OOB timing.
package oob_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COMRESET = 3'd1,
    ST_WAIT_CI  = 3'd2,
    ST_COMWAKE  = 3'd3,
    ST_WAIT_CW  = 3'd4,
    ST_ALIGN    = 3'd5,
    ST_LINK_UP  = 3'd6,
    ST_FAIL     = 3'd7
  } oob_state_t;

  localparam logic [1:0] PRIM_ALIGN = 2'd0;
  localparam logic [1:0] PRIM_SYNC  = 2'd1;

  localparam int UIOOB     = 160;
  localparam int RESET_GAP = 480;
  localparam int N_BURST   = 6;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/oob_burst_timer.sv
// Burst/gap train generator shared by COMRESET and COMWAKE. Lengths are
// latched on i_start; o_burst_nxt is the burst level for the following cycle.
module oob_burst_timer #(
  parameter int PW = 9,
  parameter int BW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [PW-1:0] i_burst_m1,
  input  logic [PW-1:0] i_gap_m1,
  input  logic [BW-1:0] i_count_m1,
  output logic          o_burst_nxt,
  output logic          o_done
);

  logic          active;
  logic          in_burst;
  logic [PW-1:0] phase_cnt;
  logic [PW-1:0] burst_m1;
  logic [PW-1:0] gap_m1;
  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] count_m1;
  logic          burst_end;
  logic          gap_end;

  assign burst_end = active & in_burst & (phase_cnt == burst_m1);
  assign gap_end   = active & ~in_burst & (phase_cnt == gap_m1);
  // o_done marks the last cycle of the final gap so the caller can leave on the next edge.
  assign o_done    = gap_end & (burst_cnt == count_m1);

  always_comb begin
    o_burst_nxt = i_start | (active & in_burst & ~burst_end) | (gap_end & ~o_done);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active    <= 1'b0;
      in_burst  <= 1'b0;
      phase_cnt <= '0;
      burst_cnt <= '0;
      burst_m1  <= '0;
      gap_m1    <= '0;
      count_m1  <= '0;
    end else if (i_start) begin
      active    <= 1'b1;
      in_burst  <= 1'b1;
      phase_cnt <= '0;
      burst_cnt <= '0;
      burst_m1  <= i_burst_m1;
      gap_m1    <= i_gap_m1;
      count_m1  <= i_count_m1;
    end else if (active) begin
      if (burst_end) begin
        in_burst  <= 1'b0;
        phase_cnt <= '0;
      end else if (o_done) begin
        active    <= 1'b0;
        phase_cnt <= '0;
        burst_cnt <= '0;
      end else if (gap_end) begin
        in_burst  <= 1'b1;
        phase_cnt <= '0;
        burst_cnt <= burst_cnt + 1'b1;
      end else begin
        phase_cnt <= phase_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/oob_host_seq.sv
// Host-side SATA OOB bring-up FSM: COMRESET, wait COMINIT, COMWAKE, wait
// COMWAKE, ALIGN, LINK_UP, with timeout-driven COMRESET retries.
module oob_host_seq
  import oob_pkg::*;
#(
  parameter int UIOOB     = oob_pkg::UIOOB,
  parameter int RESET_GAP = oob_pkg::RESET_GAP,
  parameter int N_BURST   = oob_pkg::N_BURST,
  parameter int T_WAIT    = 4096,
  parameter int MAX_RETRY = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_cominit_det,
  input  logic       i_comwake_det,
  input  logic       i_align_det,
  output logic       o_burst_en,
  output logic [1:0] o_prim_sel,
  output logic       o_link_up,
  output logic       o_fail,
  output logic [2:0] o_state,
  output logic [1:0] o_retry_cnt
);

  localparam int PW = $clog2(max_int(UIOOB, RESET_GAP));
  localparam int BW = $clog2(N_BURST + 1);
  localparam int WW = $clog2(T_WAIT);

  localparam logic [WW-1:0] WAIT_LAST = WW'(T_WAIT - 1);
  localparam logic [1:0]    MAX_R     = 2'(MAX_RETRY);

  oob_state_t    state;
  oob_state_t    state_nxt;
  logic [1:0]    retry_cnt;
  logic [1:0]    retry_nxt;
  logic [WW-1:0] wait_cnt;
  logic          timeout;
  logic          waiting;
  logic          seq_start;
  logic          seq_done;
  logic          tmr_burst_nxt;
  logic [PW-1:0] gap_m1;
  logic          burst_nxt;
  logic [1:0]    prim_nxt;

  assign timeout = (wait_cnt == WAIT_LAST);
  assign waiting = (state == ST_WAIT_CI) || (state == ST_WAIT_CW) || (state == ST_ALIGN);

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    case (state)
      ST_IDLE, ST_FAIL: begin
        if (i_start) begin
          state_nxt = ST_COMRESET;
          retry_nxt = 2'd1;
        end
      end
      ST_COMRESET: if (seq_done) state_nxt = ST_WAIT_CI;
      ST_COMWAKE:  if (seq_done) state_nxt = ST_WAIT_CW;
      ST_LINK_UP:  if (i_cominit_det) state_nxt = ST_COMWAKE;
      default: begin
        // The three waiting states: a response wins over a same-cycle timeout.
        if ((state == ST_WAIT_CI) && i_cominit_det) begin
          state_nxt = ST_COMWAKE;
        end else if ((state == ST_WAIT_CW) && i_comwake_det) begin
          state_nxt = ST_ALIGN;
        end else if ((state == ST_ALIGN) && i_align_det) begin
          state_nxt = ST_LINK_UP;
        end else if (timeout) begin
          if (retry_cnt < MAX_R) begin
            state_nxt = ST_COMRESET;
            retry_nxt = retry_cnt + 2'd1;
          end else begin
            state_nxt = ST_FAIL;
          end
        end
      end
    endcase
  end

  assign seq_start = (state_nxt != state) &&
                     ((state_nxt == ST_COMRESET) || (state_nxt == ST_COMWAKE));
  assign gap_m1    = (state_nxt == ST_COMRESET) ? PW'(RESET_GAP - 1) : PW'(UIOOB - 1);

  oob_burst_timer #(.PW(PW), .BW(BW)) u_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (seq_start),
    .i_burst_m1  (PW'(UIOOB - 1)),
    .i_gap_m1    (gap_m1),
    .i_count_m1  (BW'(N_BURST - 1)),
    .o_burst_nxt (tmr_burst_nxt),
    .o_done      (seq_done)
  );

  always_comb begin
    burst_nxt = 1'b0;
    prim_nxt  = PRIM_ALIGN;
    case (state_nxt)
      ST_COMRESET, ST_COMWAKE: burst_nxt = tmr_burst_nxt;
      ST_ALIGN:                burst_nxt = 1'b1;
      ST_LINK_UP: begin
        burst_nxt = 1'b1;
        prim_nxt  = PRIM_SYNC;
      end
      default: burst_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      retry_cnt  <= 2'd0;
      wait_cnt   <= '0;
      o_burst_en <= 1'b0;
      o_prim_sel <= PRIM_ALIGN;
      o_link_up  <= 1'b0;
      o_fail     <= 1'b0;
    end else begin
      state      <= state_nxt;
      retry_cnt  <= retry_nxt;
      wait_cnt   <= (waiting && (state_nxt == state)) ? wait_cnt + 1'b1 : '0;
      o_burst_en <= burst_nxt;
      o_prim_sel <= prim_nxt;
      o_link_up  <= (state_nxt == ST_LINK_UP);
      o_fail     <= (state_nxt == ST_FAIL);
    end
  end

  assign o_state     = state;
  assign o_retry_cnt = retry_cnt;

endmodule
